// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, the
// registered control struct that carries the FSM state, and the frame length width.
package loader_pkg;

    localparam int LEN_W = 16;

    typedef enum logic [2:0] {
        HUNT   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CKS    = 3'd4,
        FIN    = 3'd5,
        ERR    = 3'd6
    } loader_state_e;

    // Everything the FSM owns lives in one struct so the state is easy to probe.
    typedef struct packed {
        loader_state_e      state;
        logic [LEN_W-1:0]   len;
        logic [7:0]         cks;
    } loader_ctl_t;

    localparam loader_ctl_t CTL_RESET = '{state: HUNT, len: '0, cks: '0};

    // FIN and ERR are the only states that refuse bytes.
    function automatic logic is_ready_state(input loader_state_e s);
        return (s != FIN) && (s != ERR);
    endfunction

endpackage

// File: rtl/loader_word_asm.sv
// Byte-to-word assembler: shifts bytes in MSB first and pulses word_valid
// the cycle after the last byte of each word has been taken.
module loader_word_asm #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic                 last_byte,
    output logic                 word_valid,
    output logic [WORD_SIZE-1:0] word
);

    localparam int BYTES = WORD_SIZE / 8;
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [CW-1:0] cnt;

    assign last_byte = (cnt == CW'(BYTES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                cnt <= '0;
            end else if (byte_valid) begin
                // Shift form works for every byte multiple, including WORD_SIZE == 8.
                word       <= (word << 8) | WORD_SIZE'(byte_data);
                cnt        <= last_byte ? '0 : cnt + CW'(1);
                word_valid <= last_byte;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction RAM; holds the core in reset while loading.
// Define LOADER_CHECKSUM_EN to require and check a trailing XOR checksum byte.
module imem_loader
    import loader_pkg::*;
#(
    parameter int          ADDR_SIZE     = 10,
    parameter int          WORD_SIZE     = 32,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter bit          HOLD_ON_RESET = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_data,
    output logic                 core_rst,
    output logic                 done,
    output logic                 error
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_SIZE;

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_e AFTER_PAYLOAD = CKS;
`else
    localparam loader_state_e AFTER_PAYLOAD = FIN;
`endif

    // Handshake: a byte moves on any clk edge where in_valid && in_ready.
    // in_ready depends only on the FSM state (and rst_n), never on in_valid.
    loader_ctl_t           ctl;
    loader_ctl_t           ctl_n;
    logic                  accept;
    logic                  frame_start;
    logic                  payload_take;
    logic                  last_byte;
    logic                  last_word;
    logic [LEN_W-1:0]      len_rx;
    logic [ADDR_SIZE-1:0]  word_cnt;

    assign in_ready  = rst_n && is_ready_state(ctl.state);
    assign accept    = in_valid && in_ready;
    assign done      = (ctl.state == FIN);
    assign len_rx    = {ctl.len[LEN_W-1:8], in_data};
    assign last_word = ((32'(word_cnt) + 32'd1) == 32'(ctl.len));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctl <= CTL_RESET;
        end else begin
            ctl <= ctl_n;
        end
    end

    always_comb begin
        ctl_n        = ctl;
        frame_start  = 1'b0;
        payload_take = 1'b0;
        case (ctl.state)
            HUNT: begin
                if (accept && (in_data == SYNC_BYTE)) begin
                    ctl_n.state = LEN_HI;
                    ctl_n.cks   = '0;
                    frame_start = 1'b1;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    ctl_n.len   = {in_data, {(LEN_W-8){1'b0}}};
                    ctl_n.state = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    ctl_n.len = len_rx;
                    // Bounding LEN here is what keeps the write address from wrapping.
                    if (32'(len_rx) > DEPTH) begin
                        ctl_n.state = ERR;
                    end else if (len_rx == '0) begin
                        ctl_n.state = AFTER_PAYLOAD;
                    end else begin
                        ctl_n.state = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    payload_take = 1'b1;
                    ctl_n.cks    = ctl.cks ^ in_data;
                    if (last_byte && last_word) begin
                        ctl_n.state = AFTER_PAYLOAD;
                    end
                end
            end
            CKS: begin
                if (accept) begin
                    ctl_n.state = (in_data == ctl.cks) ? FIN : ERR;
                end
            end
            FIN:     ctl_n.state = HUNT;
            ERR:     ctl_n.state = HUNT;
            default: ctl_n.state = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_cnt <= '0;
            mem_addr <= '0;
            core_rst <= HOLD_ON_RESET;
            error    <= 1'b0;
        end else begin
            if (frame_start) begin
                word_cnt <= '0;
                error    <= 1'b0;
                core_rst <= 1'b1;
            end
            // Address is captured with the completing byte so it lines up with mem_we.
            if (payload_take && last_byte) begin
                mem_addr <= word_cnt;
                word_cnt <= word_cnt + ADDR_SIZE'(1);
            end
            if (ctl_n.state == ERR) begin
                error <= 1'b1;
            end
            if (ctl.state == FIN) begin
                core_rst <= 1'b0;
            end
        end
    end

    loader_word_asm #(
        .WORD_SIZE (WORD_SIZE)
    ) u_word_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (frame_start),
        .byte_valid (payload_take),
        .byte_data  (in_data),
        .last_byte  (last_byte),
        .word_valid (mem_we),
        .word       (mem_data)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames are modelled as word lists, expected
// writes are queued at issue time and a negedge monitor checks every mem_we.
module tb_imem_loader;
    import loader_pkg::*;

    localparam int         ADDR_SIZE = 10;
    localparam int         WORD_SIZE = 32;
    localparam logic [7:0] SYNC      = 8'hA5;
    localparam bit         HOLD      = 1'b0;
    localparam int         DEPTH     = 1 << ADDR_SIZE;
    localparam int         W         = ADDR_SIZE + WORD_SIZE;
`ifdef LOADER_CHECKSUM_EN
    localparam bit         CKS_EN    = 1'b1;
`else
    localparam bit         CKS_EN    = 1'b0;
`endif

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic [7:0]           in_data;
    logic                 in_ready;
    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_data;
    logic                 core_rst;
    logic                 done;
    logic                 error;

    logic [W-1:0]         exp_q[$];
    logic [WORD_SIZE-1:0] payload_q[$];
    logic [W-1:0]         mon_exp;
    int                   checks   = 0;
    int                   errors   = 0;
    int                   done_cnt = 0;

    imem_loader #(
        .ADDR_SIZE     (ADDR_SIZE),
        .WORD_SIZE     (WORD_SIZE),
        .SYNC_BYTE     (SYNC),
        .HOLD_ON_RESET (HOLD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .core_rst (core_rst),
        .done     (done),
        .error    (error)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #700000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                             mem_addr, mem_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("write", 64'({mem_addr, mem_data}), 64'(mon_exp));
                end
            end
            if (done) done_cnt++;
        end
    end

    // drivers
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  g;
        bit  ok;
        g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        in_valid = 1'b0;
        repeat (g) begin
            in_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        ok       = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: got in_ready=0 for 50 cycles expected acceptance of %0h", b);
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) payload_q.push_back(WORD_SIZE'($urandom));
    endtask

    // Reference: a frame of LEN words lands at addresses 0..LEN-1 when LEN fits;
    // success needs LEN to fit and, with checksum enabled, a correct XOR byte.
    task automatic run_frame(input int len, input bit bad_cks, input int junk);
        logic [7:0]  b;
        logic [7:0]  x;
        bit          len_ok;
        bit          exp_done;
        int          d0;
        len_ok   = (len <= DEPTH);
        exp_done = len_ok && !(CKS_EN && bad_cks);
        if (len_ok) begin
            for (int i = 0; i < len; i++) exp_q.push_back({ADDR_SIZE'(i), payload_q[i]});
        end
        for (int j = 0; j < junk; j++) begin
            do b = 8'($urandom); while (b == SYNC);
            send_byte(b);
        end
        d0 = done_cnt;
        send_byte(SYNC);
        @(negedge clk);
        check("core_rst_loading", 64'(core_rst), 64'(1));
        check("error_cleared_by_sync", 64'(error), 64'(0));
        @(posedge clk);
        #1;
        send_byte(8'(len >> 8));
        send_byte(8'(len));
        x = 8'h00;
        if (len_ok) begin
            for (int i = 0; i < len; i++) begin
                for (int k = WORD_SIZE / 8 - 1; k >= 0; k--) begin
                    b = payload_q[i][k*8 +: 8];
                    x = x ^ b;
                    send_byte(b);
                end
            end
            if (CKS_EN) send_byte(bad_cks ? (x ^ 8'h01) : x);
        end
        idle(4);
        check("done_pulses", 64'(done_cnt - d0), 64'(exp_done));
        check("error_flag", 64'(error), 64'(!exp_done));
        check("core_rst_after", 64'(core_rst), 64'(!exp_done));
        check("writes_outstanding", 64'(exp_q.size()), 64'(0));
        check("ready_idle", 64'(in_ready), 64'(1));
        payload_q.delete();
    endtask

    task automatic load_scenario2();
        payload_q.push_back(32'hDEADBEEF);
        payload_q.push_back(32'h01020304);
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_error", 64'(error), 64'(0));
        check("rst_core_rst", 64'(core_rst), 64'(HOLD));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_data", 64'(mem_data), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        check("ready_after_reset", 64'(in_ready), 64'(1));
        check("state_hunt", 64'(dut.ctl.state), 64'(HUNT));

        // leading garbage then the reference two-word frame
        send_byte(8'h11);
        send_byte(8'h22);
        load_scenario2();
        run_frame(2, 1'b0, 0);

        // same frame with a wrong checksum (plain good frame when checksum is off)
        load_scenario2();
        run_frame(2, 1'b1, 0);

        // length one past the memory depth, then the exact depth
        run_frame(DEPTH + 1, 1'b0, 0);
        run_frame(0, 1'b0, 0);
        fill_random(DEPTH);
        run_frame(DEPTH, 1'b0, 1);

        // sync byte values inside the payload are plain data
        payload_q.push_back(32'hA5A5A5A5);
        payload_q.push_back(32'h000000A5);
        run_frame(2, 1'b0, 0);

        repeat (8) begin
            n = $urandom_range(1, 6);
            fill_random(n);
            run_frame(n, ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
        end

        // reset in the middle of a frame aborts it without writes
        send_byte(SYNC);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'hDE);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        check("abort_state_hunt", 64'(dut.ctl.state), 64'(HUNT));
        check("abort_in_ready", 64'(in_ready), 64'(1));
        check("abort_error", 64'(error), 64'(0));
        check("abort_core_rst", 64'(core_rst), 64'(HOLD));
        check("abort_no_writes", 64'(exp_q.size()), 64'(0));
        load_scenario2();
        run_frame(2, 1'b0, 0);

        idle(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
